// File: rtl/arm_pkg.sv
// Shared operand-2 definitions: shift-type codes, operand forms and the
// decoded control word carried between the decode and shift stages.
package arm_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        FORM_LDST,
        FORM_IMM,
        FORM_REGSHIFT,
        FORM_IMMSHIFT
    } form_e;

    // Width-independent part of the decoded operand; the source value and the
    // effective amount depend on DATA_W and are registered alongside it.
    typedef struct packed {
        form_e      form;
        logic [1:0] sh_type;
        logic       over;   // LSL/LSR by more than DATA_W: result and carry are 0
        logic       rrx;    // rotate right extended through c_in
        logic       c_in;
    } dec_ctrl_t;

    // Operand form selection: load/store > immediate > register shift > immediate shift
    function automatic form_e decode_form(input logic is_ld_st, input logic imm,
                                          input logic reg_shift);
        if (is_ld_st)       return FORM_LDST;
        else if (imm)       return FORM_IMM;
        else if (reg_shift) return FORM_REGSHIFT;
        else                return FORM_IMMSHIFT;
    endfunction

endpackage

// File: rtl/val2_shift_core.sv
// Combinational barrel shifter and carry select for the final pipeline stage.
// The amount is already saturated to 0..DATA_W; out-of-range cases arrive
// pre-decoded as the over/rrx flags.
module val2_shift_core
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  form_e               form,
    input  logic [1:0]          sh_type,
    input  logic [SHAMT_W:0]    amt,
    input  logic                over,
    input  logic                rrx,
    input  logic                c_in,
    input  logic [DATA_W-1:0]   src,
    output logic [DATA_W-1:0]   val2,
    output logic                carry_out
);

    localparam logic [SHAMT_W:0] AMT_FULL = (SHAMT_W+1)'(DATA_W);

    logic [DATA_W:0]   lsl_w;
    logic [DATA_W:0]   lsr_w;
    logic [DATA_W:0]   asr_w;
    logic [DATA_W-1:0] ror_v;

    // One extra bit beside each shift catches the last bit shifted out,
    // which also yields the right carry when amt equals DATA_W.
    always_comb begin
        lsl_w = {1'b0, src} << amt;
        lsr_w = {src, 1'b0} >> amt;
        asr_w = $signed({src, 1'b0}) >>> amt;
        ror_v = (src >> amt) | (src << (AMT_FULL - amt));

        val2      = src;
        carry_out = c_in;
        if (form == FORM_LDST) begin
            val2      = src;
            carry_out = c_in;
        end else if (rrx) begin
            val2      = {c_in, src[DATA_W-1:1]};
            carry_out = src[0];
        end else if (over) begin
            val2      = '0;
            carry_out = 1'b0;
        end else if (amt != '0) begin
            case (sh_type)
                SH_LSL:  {carry_out, val2} = lsl_w;
                SH_LSR:  {val2, carry_out} = lsr_w;
                SH_ASR:  {val2, carry_out} = asr_w;
                default: begin
                    val2      = ror_v;
                    carry_out = ror_v[DATA_W-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/val2_shift_pipe.sv
// Pipelined operand-2 generator: decodes the operand form and effective shift
// amount, then barrel-shifts in the final stage behind a valid/ready handshake.
module val2_shift_pipe
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned SHAMT_W     = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rm,
    input  logic [7:0]        rs,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              is_ld_st,
    input  logic              reg_shift,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val2,
    output logic              shifter_carry
);

    localparam logic [SHAMT_W:0] AMT_FULL = (SHAMT_W+1)'(DATA_W);

    dec_ctrl_t          d_ctrl;
    logic [SHAMT_W:0]   d_amt;
    logic [DATA_W-1:0]  d_src;
    logic [31:0]        rs_n;
    logic [4:0]         imm_n;
    logic [SHAMT_W-1:0] rs_mod;

    // Bit 4 only distinguishes register shifts in the encoding; reg_shift carries that.
    logic unused_so_bit4;
    assign unused_so_bit4 = shift_operand[4];

    // Decode: reduce every operand form to (source, type, saturated amount, flags).
    // Immediate and load/store forms reuse the shifter as ROR/pass-through.
    always_comb begin
        d_ctrl.form    = decode_form(is_ld_st, imm, reg_shift);
        d_ctrl.sh_type = shift_operand[6:5];
        d_ctrl.over    = 1'b0;
        d_ctrl.rrx     = 1'b0;
        d_ctrl.c_in    = c_in;
        d_amt          = '0;
        d_src          = rm;
        rs_n           = 32'(rs);
        imm_n          = shift_operand[11:7];
        rs_mod         = rs_n[SHAMT_W-1:0];
        case (d_ctrl.form)
            FORM_LDST: begin
                d_src          = DATA_W'(shift_operand);
                d_ctrl.sh_type = SH_LSL;
            end
            FORM_IMM: begin
                d_src          = DATA_W'(shift_operand[7:0]);
                d_ctrl.sh_type = SH_ROR;
                d_amt          = (SHAMT_W+1)'({shift_operand[11:8], 1'b0});
            end
            FORM_REGSHIFT: begin
                if (rs_n != '0) begin
                    if (d_ctrl.sh_type == SH_ROR) begin
                        d_amt = (rs_mod == '0) ? AMT_FULL : {1'b0, rs_mod};
                    end else if (rs_n >= DATA_W) begin
                        d_amt       = AMT_FULL;
                        d_ctrl.over = (rs_n > DATA_W) && (d_ctrl.sh_type != SH_ASR);
                    end else begin
                        d_amt = rs_n[SHAMT_W:0];
                    end
                end
            end
            default: begin
                if (imm_n != '0) begin
                    d_amt = (SHAMT_W+1)'(imm_n);
                end else if (d_ctrl.sh_type == SH_LSR || d_ctrl.sh_type == SH_ASR) begin
                    d_amt = AMT_FULL;
                end else if (d_ctrl.sh_type == SH_ROR) begin
                    d_ctrl.rrx = 1'b1;
                end
            end
        endcase
    end

    logic              out_adv;
    logic              up_valid;
    dec_ctrl_t         x_ctrl;
    logic [SHAMT_W:0]  x_amt;
    logic [DATA_W-1:0] x_src;
    logic [DATA_W-1:0] core_val2;
    logic              core_carry;

    assign out_adv = !out_valid || out_ready;

    generate
        if (PIPE_STAGES >= 2) begin : g_two
            logic              s1_valid;
            dec_ctrl_t         s1_ctrl;
            logic [SHAMT_W:0]  s1_amt;
            logic [DATA_W-1:0] s1_src;

            assign in_ready = flush || !s1_valid || out_adv;
            assign up_valid = s1_valid;
            assign x_ctrl   = s1_ctrl;
            assign x_amt    = s1_amt;
            assign x_src    = s1_src;

            // Decode-stage occupancy: squashed by flush, refilled when it advances
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                end else if (flush) begin
                    s1_valid <= 1'b0;
                end else if (!s1_valid || out_adv) begin
                    s1_valid <= in_valid;
                end
            end

            // Decode-stage payload, captured only on an accepted input
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_ctrl <= '0;
                    s1_amt  <= '0;
                    s1_src  <= '0;
                end else if (in_valid && in_ready && !flush) begin
                    s1_ctrl <= d_ctrl;
                    s1_amt  <= d_amt;
                    s1_src  <= d_src;
                end
            end
        end else begin : g_one
            assign in_ready = flush || out_adv;
            assign up_valid = in_valid;
            assign x_ctrl   = d_ctrl;
            assign x_amt    = d_amt;
            assign x_src    = d_src;
        end
    endgenerate

    val2_shift_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .form      (x_ctrl.form),
        .sh_type   (x_ctrl.sh_type),
        .amt       (x_amt),
        .over      (x_ctrl.over),
        .rrx       (x_ctrl.rrx),
        .c_in      (x_ctrl.c_in),
        .src       (x_src),
        .val2      (core_val2),
        .carry_out (core_carry)
    );

    // Output-stage occupancy: squashed by flush, refilled when the consumer frees it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_adv) begin
            out_valid <= up_valid;
        end
    end

    // Output payload, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val2          <= '0;
            shifter_carry <= 1'b0;
        end else if (!flush && out_adv && up_valid) begin
            val2          <= core_val2;
            shifter_carry <= core_carry;
        end
    end

endmodule

// File: tb/tb_val2_shift_pipe.sv
// Self-checking bench for val2_shift_pipe: directed corner cases, backpressure,
// flush and async reset, then randomized traffic against a bit-serial model.
module tb_val2_shift_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PIPE   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rm;
    logic [7:0]        rs;
    logic [11:0]       shift_operand;
    logic              imm;
    logic              is_ld_st;
    logic              reg_shift;
    logic              c_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] val2;
    logic              shifter_carry;

    always #5 clk = ~clk;

    val2_shift_pipe #(
        .DATA_W      (DATA_W),
        .PIPE_STAGES (PIPE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rm            (rm),
        .rs            (rs),
        .shift_operand (shift_operand),
        .imm           (imm),
        .is_ld_st      (is_ld_st),
        .reg_shift     (reg_shift),
        .c_in          (c_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .val2          (val2),
        .shifter_carry (shifter_carry)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [32:0] exp_q[$];
    logic        last_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift one bit position at a time, n times; carry is the last bit moved out.
    function automatic logic [32:0] shift_steps(input logic [1:0] ty, input logic [31:0] v0,
                                                input int unsigned n, input logic c0);
        logic [31:0] v;
        logic        c;
        v = v0;
        c = c0;
        for (int unsigned i = 0; i < n; i++) begin
            case (ty)
                2'd0:    begin c = v[31]; v = {v[30:0], 1'b0}; end
                2'd1:    begin c = v[0];  v = {1'b0, v[31:1]}; end
                2'd2:    begin c = v[0];  v = {v[31], v[31:1]}; end
                default: begin c = v[0];  v = {v[0], v[31:1]}; end
            endcase
        end
        return {c, v};
    endfunction

    function automatic logic [32:0] ref_val2(input logic [31:0] rm_v, input logic [7:0] rs_v,
                                             input logic [11:0] so, input logic imm_v,
                                             input logic ldst_v, input logic rsh_v,
                                             input logic cin);
        logic [1:0]  ty;
        int unsigned n;
        ty = so[6:5];
        if (ldst_v) return {cin, 20'b0, so};
        if (imm_v)  return shift_steps(2'd3, {24'b0, so[7:0]}, 2 * int'(so[11:8]), cin);
        if (rsh_v)  return shift_steps(ty, rm_v, int'(rs_v), cin);
        n = int'(so[11:7]);
        if (n == 0) begin
            case (ty)
                2'd0:    return {cin, rm_v};
                2'd3:    return {rm_v[0], cin, rm_v[31:1]};
                default: return shift_steps(ty, rm_v, 32, cin);
            endcase
        end
        return shift_steps(ty, rm_v, n, cin);
    endfunction

    // One clock: check output against scoreboard head, record acceptance, advance.
    task automatic tick();
        #1;
        last_acc = in_valid && in_ready && !flush;
        if (exp_q.size() == 0) begin
            check_eq("idle_out_valid", out_valid, 1'b0);
        end else if (out_valid) begin
            check_eq("result", {shifter_carry, val2}, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
        end
        if (flush) exp_q.delete();
        else if (last_acc)
            exp_q.push_back(ref_val2(rm, rs, shift_operand, imm, is_ld_st, reg_shift, c_in));
        @(negedge clk);
    endtask

    task automatic set_op(input logic [31:0] rm_v, input logic [7:0] rs_v, input logic [11:0] so,
                          input logic imm_v, input logic ldst_v, input logic rsh_v, input logic cin);
        rm            = rm_v;
        rs            = rs_v;
        shift_operand = so;
        imm           = imm_v;
        is_ld_st      = ldst_v;
        reg_shift     = rsh_v;
        c_in          = cin;
    endtask

    task automatic run_one(input string tag, input logic [31:0] rm_v, input logic [7:0] rs_v,
                           input logic [11:0] so, input logic imm_v, input logic ldst_v,
                           input logic rsh_v, input logic cin, input logic [32:0] exp);
        int unsigned lat;
        set_op(rm_v, rs_v, so, imm_v, ldst_v, rsh_v, cin);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
            #1;
        end
        check_eq({tag, "_latency"}, lat, PIPE);
        check_eq(tag, {shifter_carry, val2}, exp);
        tick();
    endtask

    task automatic drain(input string tag);
        int unsigned cyc;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 12) begin
            tick();
            cyc++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    int unsigned rs_pick[6] = '{0, 31, 32, 33, 64, 255};

    initial begin
        int unsigned idx;
        int unsigned cyc;
        logic [31:0] bp_rm[4];
        logic [11:0] bp_so[4];

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        last_acc = 1'b0;

        // Reset values
        @(negedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_val2", val2, 32'h0);
        check_eq("rst_carry", shifter_carry, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Directed corner cases
        run_one("rot_imm",   32'h0,        8'd0,  12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0, {1'b1, 32'hFF000000});
        run_one("asr_imm0",  32'h80000001, 8'd0,  12'h040, 1'b0, 1'b0, 1'b0, 1'b0, {1'b1, 32'hFFFFFFFF});
        run_one("rrx",       32'h00000003, 8'd0,  12'h060, 1'b0, 1'b0, 1'b0, 1'b1, {1'b1, 32'h80000001});
        run_one("lsl_rs32",  32'h00000001, 8'd32, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, {1'b1, 32'h0});
        run_one("lsl_rs33",  32'h00000001, 8'd33, 12'h010, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 32'h0});
        run_one("lsr_imm0",  32'h80000000, 8'd0,  12'h020, 1'b0, 1'b0, 1'b0, 1'b0, {1'b1, 32'h0});
        run_one("ror_rs64",  32'h80000001, 8'd64, 12'h070, 1'b0, 1'b0, 1'b1, 1'b0, {1'b1, 32'h80000001});
        run_one("reg_rs0",   32'h12345678, 8'd0,  12'h050, 1'b0, 1'b0, 1'b1, 1'b1, {1'b1, 32'h12345678});
        run_one("ldst",      32'hFFFFFFFF, 8'd9,  12'hABC, 1'b1, 1'b1, 1'b1, 1'b1, {1'b1, 32'h00000ABC});
        run_one("lsl_imm4",  32'h90000001, 8'd0,  12'h200, 1'b0, 1'b0, 1'b0, 1'b0, {1'b1, 32'h00000010});

        // Backpressure: four back-to-back inputs, consumer stalled for three cycles
        bp_rm = '{32'h11111111, 32'h80000000, 32'hF0F0F0F0, 32'h00000005};
        bp_so = '{12'h080, 12'h0A0, 12'h0C0, 12'h0E0};
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            out_ready = (cyc >= 3);
            set_op(bp_rm[idx], 8'd0, bp_so[idx], 1'b0, 1'b0, 1'b0, 1'b1);
            in_valid = 1'b1;
            if (cyc == 2) begin
                #1;
                check_eq("bp_in_ready_full", in_ready, 1'b0);
                check_eq("bp_out_valid_stall", out_valid, 1'b1);
            end
            tick();
            if (last_acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("bp_all_accepted", idx, 4);
        drain("bp_drain_empty");

        // Flush with two entries in flight; the concurrent input is dropped
        out_ready = 1'b0;
        set_op(32'hCAFEF00D, 8'd4, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        #1;
        check_eq("flush_in_ready", in_ready, 1'b1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("flush_out_valid", out_valid, 1'b0);
        tick();
        tick();

        // Asynchronous reset while a result is stalled at the output
        out_ready = 1'b0;
        set_op(32'h0, 8'd0, 12'h5A5, 1'b0, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        check_eq("arst_pre_val2", {shifter_carry, val2}, {1'b1, 32'h000005A5});
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_val2", val2, 32'h0);
        check_eq("arst_carry", shifter_carry, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("arst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Randomized traffic with random stalls and occasional flush
        for (int i = 0; i < 800; i++) begin
            rm            = $urandom;
            shift_operand = 12'($urandom);
            if ($urandom_range(0, 3) == 0) shift_operand[11:7] = 5'd0;
            rs            = ($urandom_range(0, 2) == 0) ? 8'(rs_pick[$urandom_range(0, 5)])
                                                        : 8'($urandom);
            imm           = ($urandom_range(0, 3) == 0);
            is_ld_st      = ($urandom_range(0, 5) == 0);
            reg_shift     = 1'($urandom);
            c_in          = 1'($urandom);
            in_valid      = ($urandom_range(0, 9) < 7);
            out_ready     = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 39) == 0);
            tick();
        end
        drain("rand_drain_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/val2_shift_pipe.md
Name: val2_shift_pipe

Overview:
- Pipelined, parametrised successor to the combinational operand-2 generator in the EXE stage.
- Produces the second ALU operand (val2) and the shifter carry-out for three operand forms: rotated immediate, immediate-amount register shift, and register-amount register shift (Rs[7:0]).
- Elastic valid/ready pipeline with flush, so a multi-cycle EXE path can stall or squash it.
- Sits between ID/EX register read and the ALU; the ALU consumes shifter_carry for logical ops with S set.

Parameters:
- DATA_W, 32, datapath width; power of two, >= 32.
- PIPE_STAGES, 2, latency in cycles; legal values 1 or 2 (1 = output register only, 2 = decode register + output register).
- SHAMT_W, $clog2(DATA_W), derived; width of the internal effective shift amount.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous squash of all in-flight entries.
- in_valid  in  1  input request valid.
- in_ready  out  1  block accepts the input this cycle.
- rm  in  DATA_W  value of register Rm.
- rs  in  8  low byte of register Rs (shift-by-register amount).
- shift_operand  in  12  instruction bits [11:0].
- imm  in  1  I bit: rotated-immediate form.
- is_ld_st  in  1  load/store offset form.
- reg_shift  in  1  shift amount taken from rs; only meaningful when imm=0 and is_ld_st=0.
- c_in  in  1  current CPSR C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- val2  out  DATA_W  generated operand.
- shifter_carry  out  1  shifter carry-out.

Behaviour:
- Reset: while rst_n=0, all stage valids=0, out_valid=0, val2=0, shifter_carry=0. in_ready=1 once reset is released.
- Handshake:
  - A transfer occurs on any cycle with valid & ready high.
  - Each stage advances when it is empty or its downstream stage advances.
  - in_ready = !stage1_valid | stage1_advance. in_ready is combinational from out_ready (no skid buffer).
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Latency: an accepted input appears on out_valid PIPE_STAGES cycles later if no stall occurs. Full throughput is 1 result per cycle.
- Priority of forms: is_ld_st > imm > reg_shift > immediate shift.
- Load/store form: val2 = zero-extend(shift_operand); shifter_carry = c_in.
- Rotated-immediate form:
  - val2 = zero-extend(shift_operand[7:0]) rotated right by 2*shift_operand[11:8].
  - shifter_carry = c_in if rotate amount = 0, else val2[DATA_W-1].
- Shift type comes from shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR (sign fill from rm[DATA_W-1]), 11 ROR.
- Immediate-amount shift, n = shift_operand[11:7]:
  - LSL #0: val2 = rm, carry = c_in.
  - LSR #0 is treated as LSR #32: val2 = 0, carry = rm[31].
  - ASR #0 is treated as ASR #32: val2 = all sign, carry = rm[DATA_W-1].
  - ROR #0 is RRX: val2 = {c_in, rm[DATA_W-1:1]}, carry = rm[0].
  - Otherwise carry = the last bit shifted out.
- Register-amount shift, n = rs[7:0]:
  - n = 0: val2 = rm, carry = c_in, for all types.
  - LSL: n < DATA_W normal; n = DATA_W gives 0 with carry rm[0]; n > DATA_W gives 0 with carry 0.
  - LSR: same as LSL, with carry rm[DATA_W-1] at n = DATA_W.
  - ASR: n >= DATA_W gives all sign, carry = sign.
  - ROR: rotate by n mod DATA_W. If n != 0 and n mod DATA_W = 0, val2 = rm and carry = rm[DATA_W-1].
- Stage split when PIPE_STAGES=2:
  - Stage 1 registers: form, type, saturated effective amount (SHAMT_W+1 bits), the special-case flags, rm and c_in.
  - Stage 2 performs the barrel shift and carry select.
  - When PIPE_STAGES=1, decode and shift are both combinational into the output register.
- Flush: clears all valids at the next clock edge. An input presented in the same cycle as flush is dropped. in_ready=1 during flush. Datapath registers keep their stale values.
- Reset asserted mid-operation drops all entries immediately (asynchronous).

Decomposition:
- Shared package arm_pkg holds:
  - shift-type constants SH_LSL/SH_LSR/SH_ASR/SH_ROR;
  - the operand-form enum (FORM_LDST, FORM_IMM, FORM_REGSHIFT, FORM_IMMSHIFT);
  - the decoded-stage struct.
- One natural sub-module, val2_shift_core: purely combinational barrel shifter plus carry select, parametrised by DATA_W. It is instantiated in the final stage.

Test Plan:
- Rotated immediate: imm=1, shift_operand=0x4FF → val2=0xFF000000, carry=1 after PIPE_STAGES cycles.
- Immediate ASR #0: rm=0x80000001, type ASR, n=0, c_in=0 → val2=0xFFFFFFFF, carry=1.
- RRX: rm=0x00000003, type ROR, n=0, c_in=1 → val2=0x80000001, carry=1.
- Register LSL: rs=32 with rm=0x00000001 → val2=0, carry=1. rs=33 → val2=0, carry=0.
- Backpressure: 4 back-to-back inputs with out_ready held 0 for 3 cycles → no loss or duplication, results in order, val2 stable while stalled, in_ready=0 once full.
- Flush and reset: 2 entries in flight, flush=1 → out_valid=0 next cycle. Then assert rst_n=0 asynchronously mid-transfer → val2=0 and out_valid=0 without waiting for a clock edge.
